ysyx_22050019_regs_sb: RTL and testbench

- Parametrised integer register file for the pipelined core.
- Configurable numbers of read and write ports, with write-to-read forwarding within the same cycle.
- Per-register pending-write scoreboard (saturating counters) so decode can detect RAW hazards against in-flight producers.
- Registered debug read port for difftest and trace.
- Sits between decode/issue (read ports, issue marking) and writeback (write ports).

---
 rtl/ysyx_22050019_regs_sb_if.sv | 34 +++
 rtl/ysyx_22050019_regs_sb.sv | 104 ++++++++++
 tb/tb_ysyx_22050019_regs_sb.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050019_regs_sb_if.sv
// Bundle between decode/issue, writeback and the integer register file with
// its pending-write scoreboard; clk/rst stay outside as plain ports.
interface ysyx_22050019_regs_sb_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NR_READ    = 2,
    parameter int NR_WRITE   = 2
);
    logic [NR_READ*ADDR_WIDTH-1:0]  rd_addr;
    logic [NR_READ*DATA_WIDTH-1:0]  rd_data;
    logic [NR_READ-1:0]             rd_busy;
    logic [NR_WRITE-1:0]            wr_en;
    logic [NR_WRITE*ADDR_WIDTH-1:0] wr_addr;
    logic [NR_WRITE*DATA_WIDTH-1:0] wr_data;
    logic                           iss_valid;
    logic [ADDR_WIDTH-1:0]          iss_rd;
    logic                           iss_ready;
    logic                           flush;
    logic [ADDR_WIDTH-1:0]          dbg_addr;
    logic [DATA_WIDTH-1:0]          dbg_data;

    // Issue handshake: an issue is accepted on a rising edge where
    // iss_valid && iss_ready; iss_ready never looks at iss_valid, and a
    // flush in the same cycle discards the accepted issue.
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd, flush, dbg_addr,
        input  rd_data, rd_busy, iss_ready, dbg_data
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd, flush, dbg_addr,
        output rd_data, rd_busy, iss_ready, dbg_data
    );
endinterface

// File: rtl/ysyx_22050019_regs_sb.sv
// Multi-ported integer register file with same-cycle write forwarding, a
// saturating pending-write scoreboard per register and a registered debug read.
module ysyx_22050019_regs_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NR_READ    = 2,
    parameter int NR_WRITE   = 2,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_22050019_regs_sb_if.slave bus
);
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam int NQ   = NR_READ + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0]    regs_q [NREG];
    logic [CNT_WIDTH-1:0]     cnt_q  [NREG];
    logic [CNT_WIDTH-1:0]     cnt_d  [NREG];
    logic [CNT_WIDTH-1:0]     left   [NREG];
    int                       ret_cnt [NREG];
    logic [DATA_WIDTH-1:0]    dbg_q;
    logic [DATA_WIDTH-1:0]    dbg_d;
    logic [NQ*ADDR_WIDTH-1:0] q_addr;
    logic [NQ*DATA_WIDTH-1:0] q_data;
    logic [NR_READ-1:0]       busy;
    logic                     accept;

    // left[r] is the pending count once this cycle's retirements are applied.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            ret_cnt[r] = 0;
            for (int w = 0; w < NR_WRITE; w++) begin
                if (bus.wr_en[w] && bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))
                    ret_cnt[r] = ret_cnt[r] + 1;
            end
            if (r == 0 || ret_cnt[r] >= int'(cnt_q[r]))
                left[r] = '0;
            else
                left[r] = cnt_q[r] - CNT_WIDTH'(ret_cnt[r]);
        end
    end

    assign bus.iss_ready = (bus.iss_rd == '0) || (left[bus.iss_rd] != CNT_MAX);
    assign accept        = bus.iss_valid && bus.iss_ready && (bus.iss_rd != '0);

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = left[r];
            if (accept && bus.iss_rd == ADDR_WIDTH'(r))
                cnt_d[r] = left[r] + CNT_WIDTH'(1);
            if (bus.flush)
                cnt_d[r] = '0;
        end
    end

    // The debug address rides as an extra lane through the read-port mux.
    assign q_addr = {bus.dbg_addr, bus.rd_addr};

    always_comb begin
        q_data = '0;
        for (int i = 0; i < NQ; i++) begin
            q_data[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[q_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
            for (int w = 0; w < NR_WRITE; w++) begin
                if (bus.wr_en[w] &&
                    bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == q_addr[i*ADDR_WIDTH +: ADDR_WIDTH])
                    q_data[i*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
            if (q_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == '0)
                q_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NR_READ; i++)
            busy[i] = (left[bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]] != '0);
    end

    assign bus.rd_busy  = busy;
    assign bus.rd_data  = q_data[NR_READ*DATA_WIDTH-1:0];
    assign dbg_d        = q_data[NR_READ*DATA_WIDTH +: DATA_WIDTH];
    assign bus.dbg_data = dbg_q;

    // Later write ports override earlier ones through NBA ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            dbg_q <= '0;
        end else begin
            for (int w = 0; w < NR_WRITE; w++) begin
                if (bus.wr_en[w] && bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] != '0)
                    regs_q[bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= bus.wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
            for (int r = 0; r < NREG; r++)
                cnt_q[r] <= cnt_d[r];
            dbg_q <= dbg_d;
        end
    end
endmodule

// File: tb/tb_ysyx_22050019_regs_sb.sv
// Bench for the register file / scoreboard: directed scenarios on the default
// configuration, a 4-read/1-write/32-bit instance, and a randomized model run.
module tb_ysyx_22050019_regs_sb;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NR = 2;
    localparam int NW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_22050019_regs_sb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR), .NR_WRITE(NW)) bus ();
    ysyx_22050019_regs_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR), .NR_WRITE(NW), .CNT_WIDTH(2))
        dut (.clk(clk), .rst(rst), .bus(bus));

    ysyx_22050019_regs_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(4), .NR_WRITE(1)) bus2 ();
    ysyx_22050019_regs_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(4), .NR_WRITE(1), .CNT_WIDTH(2))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    logic [63:0] exp_q [$];
    logic [63:0] got, want;
    int n_vec = 0;
    int n_err = 0;
    logic [63:0] m_regs [32];
    int          m_cnt  [32];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_addr = '0; bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.iss_valid = 1'b0; bus.iss_rd = '0; bus.flush = 1'b0; bus.dbg_addr = '0;
        bus2.rd_addr = '0; bus2.wr_en = '0; bus2.wr_addr = '0; bus2.wr_data = '0;
        bus2.iss_valid = 1'b0; bus2.iss_rd = '0; bus2.flush = 1'b0; bus2.dbg_addr = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #2;
        for (int a = 0; a < 32; a++) begin
            bus.rd_addr = {AW'(a), AW'(31 - a)};
            bus.iss_rd  = AW'(a);
            exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd1);
            #1;
            got = bus.rd_data[63:0]; want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL reset_rd0 a=%0d got=%h want=%h", a, got, want); end
            got = bus.rd_data[127:64]; want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL reset_rd1 a=%0d got=%h want=%h", a, got, want); end
            got = {61'd0, bus.rd_busy, bus.iss_ready}; want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL reset_busy_ready a=%0d got=%h want=%h", a, got, want); end
        end
        exp_q.push_back(64'd0);
        got = bus.dbg_data; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL reset_dbg got=%h want=%h", got, want); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_forward();
        step(); idle();
        bus.wr_en = 2'b11; bus.wr_addr = {5'd5, 5'd5};
        bus.wr_data = {64'h5555, 64'hAAAA}; bus.rd_addr = {5'd6, 5'd5};
        exp_q.push_back(64'h5555); exp_q.push_back(64'd0);
        #2;
        got = bus.rd_data[63:0]; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL fwd_prio got=%h want=%h", got, want); end
        got = bus.rd_data[127:64]; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL fwd_lane got=%h want=%h", got, want); end
        step();
        bus.wr_en = 2'b00;
        exp_q.push_back(64'h5555);
        #2;
        got = bus.rd_data[63:0]; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL fwd_held got=%h want=%h", got, want); end
        step();
        bus.wr_en = 2'b01; bus.wr_addr = {5'd5, 5'd6};
        bus.wr_data = {64'h1111, 64'h6666}; bus.rd_addr = {5'd6, 5'd5};
        exp_q.push_back(64'h5555); exp_q.push_back(64'h6666);
        #2;
        got = bus.rd_data[63:0]; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL fwd_disabled_port got=%h want=%h", got, want); end
        got = bus.rd_data[127:64]; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL fwd_port0 got=%h want=%h", got, want); end
        step();
        bus.wr_en = 2'b01; bus.wr_addr = '0; bus.wr_data = {64'd0, 64'h1234}; bus.rd_addr = {5'd6, 5'd0};
        exp_q.push_back(64'd0);
        #2;
        got = bus.rd_data[63:0]; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL r0_fwd got=%h want=%h", got, want); end
        step();
        bus.wr_en = 2'b00;
        exp_q.push_back(64'd0); exp_q.push_back(64'h6666);
        #2;
        got = bus.rd_data[63:0]; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL r0_held got=%h want=%h", got, want); end
        got = bus.rd_data[127:64]; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL fwd_port0_held got=%h want=%h", got, want); end
    endtask

    task automatic test_scoreboard();
        step(); idle();
        bus.rd_addr = {5'd0, 5'd7}; bus.iss_rd = 5'd7;
        for (int k = 0; k < 3; k++) begin
            bus.iss_valid = 1'b1;
            exp_q.push_back(64'd1); exp_q.push_back((k != 0) ? 64'd1 : 64'd0);
            #2;
            got = {63'd0, bus.iss_ready}; want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL sb_ready k=%0d got=%h want=%h", k, got, want); end
            got = {63'd0, bus.rd_busy[0]}; want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL sb_busy k=%0d got=%h want=%h", k, got, want); end
            step();
        end
        exp_q.push_back(64'd0); exp_q.push_back(64'd1);
        #2;
        got = {63'd0, bus.iss_ready}; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL sb_sat_ready got=%h want=%h", got, want); end
        got = {63'd0, bus.rd_busy[0]}; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL sb_sat_busy got=%h want=%h", got, want); end
        step();
        bus.iss_valid = 1'b0;
        bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd7}; bus.wr_data = {64'd0, 64'h77};
        exp_q.push_back(64'd1); exp_q.push_back(64'd1);
        #2;
        got = {63'd0, bus.iss_ready}; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL sb_retire_ready got=%h want=%h", got, want); end
        got = {63'd0, bus.rd_busy[0]}; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL sb_retire_busy got=%h want=%h", got, want); end
        step();
        bus.wr_en = 2'b11; bus.wr_addr = {5'd7, 5'd7};
        exp_q.push_back(64'd0);
        #2;
        got = {63'd0, bus.rd_busy[0]}; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL sb_last_retire got=%h want=%h", got, want); end
        step();
        bus.wr_en = 2'b00; bus.iss_valid = 1'b1; bus.iss_rd = 5'd0; bus.rd_addr = {5'd0, 5'd7};
        exp_q.push_back(64'd1); exp_q.push_back(64'd0);
        #2;
        got = {63'd0, bus.iss_ready}; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL sb_r0_ready got=%h want=%h", got, want); end
        got = {62'd0, bus.rd_busy}; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL sb_drained got=%h want=%h", got, want); end
    endtask

    task automatic test_simultaneous();
        step(); idle();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
        step();
        bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd3}; bus.wr_data = {64'd0, 64'h33};
        bus.rd_addr = {5'd0, 5'd3};
        exp_q.push_back(64'd0); exp_q.push_back(64'd1);
        #2;
        got = {63'd0, bus.rd_busy[0]}; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL sim_same_cycle_busy got=%h want=%h", got, want); end
        got = {63'd0, bus.iss_ready}; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL sim_same_cycle_ready got=%h want=%h", got, want); end
        step();
        bus.wr_en = 2'b00; bus.iss_rd = 5'd10;
        exp_q.push_back(64'd1); exp_q.push_back(64'h33);
        #2;
        got = {63'd0, bus.rd_busy[0]}; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL sim_net_out got=%h want=%h", got, want); end
        got = bus.rd_data[63:0]; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL sim_net_data got=%h want=%h", got, want); end
        step();
        bus.iss_valid = 1'b0; bus.rd_addr = {5'd10, 5'd3};
        exp_q.push_back(64'd3);
        #2;
        got = {62'd0, bus.rd_busy}; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL sim_pre_flush got=%h want=%h", got, want); end
        bus.flush = 1'b1; bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
        bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd3}; bus.wr_data = {64'd0, 64'h44};
        step();
        bus.flush = 1'b0; bus.iss_valid = 1'b0; bus.wr_en = 2'b00;
        exp_q.push_back(64'd0); exp_q.push_back(64'h44);
        #2;
        got = {62'd0, bus.rd_busy}; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL sim_flush_busy got=%h want=%h", got, want); end
        got = bus.rd_data[63:0]; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL sim_flush_write got=%h want=%h", got, want); end
    endtask

    task automatic test_debug();
        step(); idle();
        bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd9}; bus.wr_data = {64'd0, 64'hDEAD}; bus.dbg_addr = 5'd9;
        step();
        bus.wr_en = 2'b00;
        exp_q.push_back(64'hDEAD);
        #2;
        got = bus.dbg_data; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL dbg_latency got=%h want=%h", got, want); end
        bus.dbg_addr = 5'd0;
        exp_q.push_back(64'hDEAD);
        #1;
        got = bus.dbg_data; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL dbg_hold got=%h want=%h", got, want); end
        step();
        exp_q.push_back(64'd0);
        #2;
        got = bus.dbg_data; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL dbg_zero got=%h want=%h", got, want); end
    endtask

    task automatic test_sweep();
        step(); idle();
        bus2.wr_en = 1'b1; bus2.wr_addr = 5'd12; bus2.wr_data = 32'hCAFEBABE;
        bus2.rd_addr = {5'd12, 5'd0, 5'd13, 5'd12};
        for (int pass = 0; pass < 2; pass++) begin
            exp_q.push_back(64'hCAFEBABE); exp_q.push_back(64'd0);
            exp_q.push_back(64'd0); exp_q.push_back(64'hCAFEBABE);
            #2;
            for (int l = 0; l < 4; l++) begin
                got = {32'd0, bus2.rd_data[l*32 +: 32]}; want = exp_q.pop_front(); n_vec++;
                if (got !== want) begin n_err++; $display("FAIL sweep_lane pass=%0d l=%0d got=%h want=%h", pass, l, got, want); end
            end
            step();
            bus2.wr_en = 1'b0; bus2.wr_addr = 5'd13; bus2.wr_data = 32'h13131313;
        end
        bus2.iss_valid = 1'b1; bus2.iss_rd = 5'd4;
        repeat (3) step();
        bus2.iss_valid = 1'b0; bus2.rd_addr = {5'd0, 5'd4, 5'd5, 5'd4};
        exp_q.push_back(64'h5); exp_q.push_back(64'd0);
        #2;
        got = {60'd0, bus2.rd_busy}; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL sweep_busy got=%h want=%h", got, want); end
        got = {63'd0, bus2.iss_ready}; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL sweep_sat got=%h want=%h", got, want); end
        bus2.wr_en = 1'b1; bus2.wr_addr = 5'd4; bus2.wr_data = 32'h00004444;
        exp_q.push_back(64'd1); exp_q.push_back(64'h00004444);
        #1;
        got = {63'd0, bus2.iss_ready}; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL sweep_retire_ready got=%h want=%h", got, want); end
        got = {32'd0, bus2.rd_data[95:64]}; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL sweep_fwd_lane2 got=%h want=%h", got, want); end
        step();
        bus2.wr_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        step(); idle();
        bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd5}; bus.wr_data = {64'd0, 64'h5A5A};
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd6; bus.dbg_addr = 5'd5;
        step();
        bus.wr_en = 2'b00; bus.iss_valid = 1'b0; bus.rd_addr = {5'd6, 5'd5};
        exp_q.push_back(64'h5A5A); exp_q.push_back(64'h5A5A); exp_q.push_back(64'd2);
        #2;
        got = bus.rd_data[63:0]; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL pre_rst_data got=%h want=%h", got, want); end
        got = bus.dbg_data; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL pre_rst_dbg got=%h want=%h", got, want); end
        got = {62'd0, bus.rd_busy}; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL pre_rst_busy got=%h want=%h", got, want); end
        rst = 1'b1;
        exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        #1;
        got = bus.rd_data[63:0]; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL rst_async_data got=%h want=%h", got, want); end
        got = bus.dbg_data; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL rst_async_dbg got=%h want=%h", got, want); end
        got = {62'd0, bus.rd_busy}; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL rst_async_busy got=%h want=%h", got, want); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0]  we;
        logic [4:0]  wa [2];
        logic [63:0] wd [2];
        logic [4:0]  ra [2];
        logic [4:0]  ir;
        logic        iv, rdy;
        int          lft [32];
        int          ret;
        for (int r = 0; r < 32; r++) begin m_regs[r] = '0; m_cnt[r] = 0; end
        for (int c = 0; c < 80; c++) begin
            step();
            we = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                wa[p] = 5'($urandom_range(0, 7));
                wd[p] = {$urandom, $urandom};
                ra[p] = 5'($urandom_range(0, 7));
            end
            ir = 5'($urandom_range(0, 7));
            iv = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < 32; r++) begin
                ret = 0;
                for (int p = 0; p < 2; p++) if (we[p] && wa[p] == 5'(r)) ret++;
                lft[r] = (r == 0 || ret >= m_cnt[r]) ? 0 : m_cnt[r] - ret;
            end
            rdy = (ir == 5'd0) || (lft[ir] != 3);
            bus.wr_en = we; bus.wr_addr = {wa[1], wa[0]}; bus.wr_data = {wd[1], wd[0]};
            bus.rd_addr = {ra[1], ra[0]}; bus.iss_valid = iv; bus.iss_rd = ir;
            for (int p = 0; p < 2; p++) begin
                if (ra[p] == 5'd0) exp_q.push_back(64'd0);
                else if (we[1] && wa[1] == ra[p]) exp_q.push_back(wd[1]);
                else if (we[0] && wa[0] == ra[p]) exp_q.push_back(wd[0]);
                else exp_q.push_back(m_regs[ra[p]]);
                exp_q.push_back((lft[ra[p]] != 0) ? 64'd1 : 64'd0);
            end
            exp_q.push_back({63'd0, rdy});
            #2;
            for (int p = 0; p < 2; p++) begin
                got = bus.rd_data[p*64 +: 64]; want = exp_q.pop_front(); n_vec++;
                if (got !== want) begin n_err++; $display("FAIL rand_data c=%0d p=%0d got=%h want=%h", c, p, got, want); end
                got = {63'd0, bus.rd_busy[p]}; want = exp_q.pop_front(); n_vec++;
                if (got !== want) begin n_err++; $display("FAIL rand_busy c=%0d p=%0d got=%h want=%h", c, p, got, want); end
            end
            got = {63'd0, bus.iss_ready}; want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL rand_ready c=%0d got=%h want=%h", c, got, want); end
            for (int p = 0; p < 2; p++) if (we[p] && wa[p] != 5'd0) m_regs[wa[p]] = wd[p];
            for (int r = 1; r < 32; r++) m_cnt[r] = lft[r] + ((iv && rdy && ir == 5'(r)) ? 1 : 0);
        end
        step();
        idle();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_scoreboard();
        test_simultaneous();
        test_debug();
        test_sweep();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
